// File: rtl/sm_input_filter.sv
// Multi-bit input synchroniser with a per-bit, run-time programmable stability filter.
// A bit's filtered level follows its synchronised input once that input has differed for more
// than `threshold` cycles. Each change of the filtered level raises a one-cycle rise/fall pulse.
module sm_input_filter #(
  parameter int unsigned     SIZE        = 1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     FILTER_BITS = 16,
  parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [FILTER_BITS-1:0] threshold,
  input  logic [SIZE-1:0]        d,
  output logic [SIZE-1:0]        q,
  output logic [SIZE-1:0]        rise,
  output logic [SIZE-1:0]        fall,
  output logic                   changed
);

  logic [SYNC_STAGES-1:0][SIZE-1:0] r_sync;
  logic [SIZE-1:0][FILTER_BITS-1:0] r_cnt;
  logic [SIZE-1:0]                  r_q;
  logic [SIZE-1:0]                  r_rise;
  logic [SIZE-1:0]                  r_fall;
  logic                             r_changed;

  logic [SIZE-1:0]                  w_s;
  logic [SIZE-1:0][FILTER_BITS-1:0] w_cnt_d;
  logic [SIZE-1:0]                  w_q_d;
  logic [SIZE-1:0]                  w_rise_d;
  logic [SIZE-1:0]                  w_fall_d;
  logic                             w_changed_d;

  // The synchroniser keeps shifting even while the filter is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_cnt_d  = r_cnt;
    w_q_d    = r_q;
    w_rise_d = '0;
    w_fall_d = '0;
    if (en) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (w_s[i] == r_q[i]) begin
          w_cnt_d[i] = '0;
        end else if (r_cnt[i] >= threshold) begin
          w_q_d[i]    = w_s[i];
          w_cnt_d[i]  = '0;
          w_rise_d[i] = w_s[i];
          w_fall_d[i] = ~w_s[i];
        end else if (r_cnt[i] != {FILTER_BITS{1'b1}}) begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
    end
    w_changed_d = |{w_rise_d, w_fall_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_q       <= RESET_VALUE;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_q       <= w_q_d;
      r_rise    <= w_rise_d;
      r_fall    <= w_fall_d;
      r_changed <= w_changed_d;
    end
  end

  assign q       = r_q;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;

endmodule
